// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit living in the EX stage. One operation
//   is in flight at a time: radix-2 shift-add multiply and restoring divide,
//   one bit per cycle. The front of the pipeline is stalled while it works
//   and a single-cycle RESULT_VALID pulse hands the result to EX/MEM.
//
// Ports
//   CLK           in   rising-edge clock
//   RESET         in   asynchronous reset, active low
//   OP_VALID      in   EX holds an M-extension instruction
//   FUNCT3        in   [2:0] MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   OPERAND1      in   [XLEN-1:0] rs1 value (post-forwarding)
//   OPERAND2      in   [XLEN-1:0] rs2 value (post-forwarding)
//   FLUSH         in   squash of the EX instruction
//   STALL         out  hold PC, IF/ID and ID/EX this cycle
//   RESULT        out  [XLEN-1:0] operation result (held until next result)
//   RESULT_VALID  out  RESULT is new this cycle; EX/MEM captures it
//
// Handshake: an op is offered by holding OP_VALID=1. It is accepted at the
// first rising edge in IDLE with FLUSH=0. While STALL=1 the pipeline keeps
// OP_VALID/FUNCT3/operands steady; STALL drops in the DONE cycle, the same
// cycle RESULT_VALID=1, so ID/EX advances at the end of that cycle.
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            OP_VALID,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic            STALL,
    output logic [XLEN-1:0] RESULT,
    output logic            RESULT_VALID
);

    localparam int CW = $clog2(ITER);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   mag1;      // multiplicand / dividend magnitude
    logic [XLEN-1:0]   mag2;      // divisor magnitude
    logic              neg1;
    logic              neg2;
    logic [2*XLEN-1:0] prod;      // upper half accumulates, lower half is the multiplier
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quot;      // starts as dividend, shifts into quotient
    logic [XLEN-1:0]   result_q;

    // ---------------- acceptance decode ----------------
    logic            accept;
    logic            op1_signed;
    logic            op2_signed;
    logic            in_neg1;
    logic            in_neg2;
    logic [XLEN-1:0] in_mag1;
    logic [XLEN-1:0] in_mag2;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        accept     = (state == S_IDLE) && OP_VALID && !FLUSH;
        // MULH, MULHSU, DIV, REM: rs1 signed. MULH, DIV, REM: rs2 signed.
        op1_signed = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010) ||
                     (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
        op2_signed = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b100) ||
                     (FUNCT3 == 3'b110);
        in_neg1    = op1_signed && OPERAND1[XLEN-1];
        in_neg2    = op2_signed && OPERAND2[XLEN-1];
        in_mag1    = in_neg1 ? (~OPERAND1 + 1'b1) : OPERAND1;
        in_mag2    = in_neg2 ? (~OPERAND2 + 1'b1) : OPERAND2;
        div_zero   = FUNCT3[2] && (OPERAND2 == '0);
        div_ovf    = FUNCT3[2] && !FUNCT3[0] &&
                     (OPERAND1 == MIN_NEG) && (OPERAND2 == ALL_ONES);
        special    = div_zero || div_ovf;
        // FUNCT3[1] distinguishes REM/REMU from DIV/DIVU.
        if (div_zero) begin
            special_res = FUNCT3[1] ? OPERAND1 : ALL_ONES;
        end else begin
            special_res = FUNCT3[1] ? '0 : MIN_NEG;
        end
    end

    // ---------------- one iteration step ----------------
    logic              last;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_step;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   quot_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   div_res;

    always_comb begin
        last      = (cnt == CW'(ITER - 1));

        mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag1} : '0);
        prod_step = {mul_sum, prod[XLEN-1:1]};

        // Restoring step: trial-subtract the divisor from the shifted remainder.
        div_shift = {rem, quot[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag2};
        if (!div_diff[XLEN]) begin
            rem_step  = div_diff[XLEN-1:0];
            quot_step = {quot[XLEN-2:0], 1'b1};
        end else begin
            rem_step  = div_shift[XLEN-1:0];
            quot_step = {quot[XLEN-2:0], 1'b0};
        end

        // Sign fix-up of the final step. It is registered into RESULT on the
        // edge that enters DONE, so RESULT is already correct during DONE.
        prod_fix = (neg1 ^ neg2) ? (~prod_step + 1'b1) : prod_step;
        quot_fix = (neg1 ^ neg2) ? (~quot_step + 1'b1) : quot_step;
        rem_fix  = neg1 ? (~rem_step + 1'b1) : rem_step;

        mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        div_res  = op_q[1] ? rem_fix : quot_fix;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_nx = S_DONE;
                    end else if (FUNCT3[2]) begin
                        state_nx = S_DIV;
                    end else begin
                        state_nx = S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (FLUSH) begin
                    state_nx = S_IDLE;
                end else if (last) begin
                    state_nx = S_DONE;
                end
            end
            // A flush in DONE is left to the downstream register.
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            mag1     <= '0;
            mag2     <= '0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            prod     <= '0;
            rem      <= '0;
            quot     <= '0;
            result_q <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= FUNCT3;
                        mag1 <= in_mag1;
                        mag2 <= in_mag2;
                        neg1 <= in_neg1;
                        neg2 <= in_neg2;
                        cnt  <= '0;
                        prod <= {{XLEN{1'b0}}, in_mag2};
                        rem  <= '0;
                        quot <= in_mag1;
                        if (special) begin
                            result_q <= special_res;
                        end
                    end
                end
                S_MUL: begin
                    if (!FLUSH) begin
                        prod <= prod_step;
                        cnt  <= cnt + CW'(1);
                        if (last) begin
                            result_q <= mul_res;
                        end
                    end
                end
                S_DIV: begin
                    if (!FLUSH) begin
                        rem  <= rem_step;
                        quot <= quot_step;
                        cnt  <= cnt + CW'(1);
                        if (last) begin
                            result_q <= div_res;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign STALL        = RESET && OP_VALID && !FLUSH && (state != S_DONE);
    assign RESULT       = result_q;
    assign RESULT_VALID = (state == S_DONE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    logic        CLK;
    logic        RESET;
    logic        OP_VALID;
    logic [2:0]  FUNCT3;
    logic [31:0] OPERAND1;
    logic [31:0] OPERAND2;
    logic        FLUSH;
    logic        STALL;
    logic [31:0] RESULT;
    logic        RESULT_VALID;

    logic [31:0] exp_q[$];
    logic [31:0] last_exp;
    int          pass_cnt;
    int          total_cnt;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .OP_VALID     (OP_VALID),
        .FUNCT3       (FUNCT3),
        .OPERAND1     (OPERAND1),
        .OPERAND2     (OPERAND2),
        .FLUSH        (FLUSH),
        .STALL        (STALL),
        .RESULT       (RESULT),
        .RESULT_VALID (RESULT_VALID)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      sp;
        logic [63:0] up;
        logic [63:0] tmp;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ref_result = '0;
        case (f3)
            F_MUL: begin
                up = {32'd0, a} * {32'd0, b};
                ref_result = up[31:0];
            end
            F_MULH: begin
                sp = sa * sb;
                tmp = sp;
                ref_result = tmp[63:32];
            end
            F_MULHSU: begin
                sp = sa * ub;
                tmp = sp;
                ref_result = tmp[63:32];
            end
            F_MULHU: begin
                up = {32'd0, a} * {32'd0, b};
                ref_result = up[63:32];
            end
            F_DIV: begin
                if (b == 32'd0) ref_result = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'h8000_0000;
                else begin
                    tmp = sa / sb;
                    ref_result = tmp[31:0];
                end
            end
            F_DIVU: ref_result = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            F_REM: begin
                if (b == 32'd0) ref_result = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'd0;
                else begin
                    tmp = sa % sb;
                    ref_result = tmp[31:0];
                end
            end
            default: ref_result = (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Cycle (counted from OP_VALID rising) in which RESULT_VALID is expected.
    function automatic int lat_for(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && b == 32'd0) return 1;
        if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // ---------------- driver: one complete operation ----------------
    // Called at posedge+1. Returns at posedge+1 of the cycle after DONE.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input bit flush_done);
        int          lat;
        logic [31:0] exp;
        lat = lat_for(f3, a, b);
        OP_VALID = 1'b1;
        FUNCT3   = f3;
        OPERAND1 = a;
        OPERAND2 = b;
        exp_q.push_back(ref_result(f3, a, b));
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) begin
                @(posedge CLK);
                #1;
            end
            if (c == 1) begin
                // Inputs after acceptance must not matter.
                FUNCT3   = 3'($urandom_range(0, 7));
                OPERAND1 = $urandom;
                OPERAND2 = $urandom;
            end
            if (flush_done && c == lat) FLUSH = 1'b1;
            @(negedge CLK);
            total_cnt++;
            if (STALL !== (c < lat)) $display("FAIL stall c=%0d: got %b expected %b", c, STALL, (c < lat));
            else pass_cnt++;
            total_cnt++;
            if (RESULT_VALID !== (c == lat)) $display("FAIL result_valid c=%0d: got %b expected %b", c, RESULT_VALID, (c == lat));
            else pass_cnt++;
            if (RESULT_VALID === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_result c=%0d: got %h expected none", c, RESULT);
                end else begin
                    exp = exp_q.pop_front();
                    last_exp = exp;
                    if (RESULT !== exp) $display("FAIL result f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, RESULT, exp);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL missing_result f3=%0d a=%h b=%h: got %0d pending expected 0", f3, a, b, exp_q.size());
            exp_q.delete();
        end else pass_cnt++;
        @(posedge CLK);
        #1;
        OP_VALID = 1'b0;
        FLUSH    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        RESET    = 1'b0;
        OP_VALID = 1'b1;
        FUNCT3   = F_MUL;
        OPERAND1 = 32'd7;
        OPERAND2 = 32'd9;
        repeat (3) @(negedge CLK);
        total_cnt++;
        if (STALL !== 1'b0) $display("FAIL reset_stall: got %b expected 0", STALL); else pass_cnt++;
        total_cnt++;
        if (RESULT !== 32'd0) $display("FAIL reset_result: got %h expected 00000000", RESULT); else pass_cnt++;
        total_cnt++;
        if (RESULT_VALID !== 1'b0) $display("FAIL reset_valid: got %b expected 0", RESULT_VALID); else pass_cnt++;
        OP_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_mul;
        run_op(F_MUL,    32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op(F_MULH,   32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op(F_MULHU,  32'd7, 32'hFFFF_FFFD, 1'b0);
        // RESULT must hold after DONE.
        @(negedge CLK);
        total_cnt++;
        if (RESULT !== last_exp) $display("FAIL result_hold: got %h expected %h", RESULT, last_exp);
        else pass_cnt++;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_div;
        run_op(F_DIV,  32'hFFFF_FFEC, 32'd6, 1'b0);
        run_op(F_REM,  32'hFFFF_FFEC, 32'd6, 1'b0);
        run_op(F_DIVU, 32'd100, 32'd7, 1'b0);
        run_op(F_REMU, 32'd100, 32'd7, 1'b0);
    endtask

    task automatic test_special_div;
        run_op(F_DIV,  32'd5, 32'd0, 1'b0);
        run_op(F_REM,  32'd5, 32'd0, 1'b0);
        run_op(F_DIVU, 32'd5, 32'd0, 1'b0);
        run_op(F_REMU, 32'd5, 32'd0, 1'b0);
        run_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        // Unsigned divide of the same pattern is an ordinary 33-cycle op.
        run_op(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_reset_mid_div;
        OP_VALID = 1'b1;
        FUNCT3   = F_DIVU;
        OPERAND1 = 32'd1000;
        OPERAND2 = 32'd7;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) begin
                @(posedge CLK);
                #1;
            end
            @(negedge CLK);
            total_cnt++;
            if (STALL !== 1'b1 || RESULT_VALID !== 1'b0)
                $display("FAIL pre_reset c=%0d: got stall=%b valid=%b expected stall=1 valid=0", c, STALL, RESULT_VALID);
            else pass_cnt++;
        end
        #1;
        RESET = 1'b0;
        #1;
        total_cnt++;
        if (STALL !== 1'b0) $display("FAIL mid_reset_stall: got %b expected 0", STALL); else pass_cnt++;
        total_cnt++;
        if (RESULT !== 32'd0) $display("FAIL mid_reset_result: got %h expected 00000000", RESULT); else pass_cnt++;
        OP_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            total_cnt++;
            if (RESULT_VALID !== 1'b0) $display("FAIL aborted_valid c=%0d: got %b expected 0", c, RESULT_VALID);
            else pass_cnt++;
        end
        @(posedge CLK);
        #1;
        run_op(F_DIVU, 32'd1000, 32'd7, 1'b0);
    endtask

    task automatic test_flush;
        OP_VALID = 1'b1;
        FUNCT3   = F_MUL;
        OPERAND1 = 32'd5;
        OPERAND2 = 32'd6;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) begin
                @(posedge CLK);
                #1;
            end
            if (c == 15) FLUSH = 1'b1;
            if (c == 16) begin
                FLUSH    = 1'b0;
                OP_VALID = 1'b0;
            end
            @(negedge CLK);
            total_cnt++;
            if (STALL !== (c < 15)) $display("FAIL flush_stall c=%0d: got %b expected %b", c, STALL, (c < 15));
            else pass_cnt++;
            total_cnt++;
            if (RESULT_VALID !== 1'b0) $display("FAIL flush_valid c=%0d: got %b expected 0", c, RESULT_VALID);
            else pass_cnt++;
        end
        @(posedge CLK);
        #1;
        // Cycle 17: a fresh MUL sees IDLE and completes normally.
        run_op(F_MUL, 32'd3, 32'd4, 1'b0);
        // A flush during DONE does not suppress RESULT_VALID.
        run_op(F_DIVU, 32'd50, 32'd5, 1'b1);
    endtask

    task automatic test_back_to_back;
        run_op(F_MULHSU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(F_DIVU,   32'd9, 32'd3, 1'b0);
        run_op(F_REM,    32'd5, 32'd0, 1'b0);
        run_op(F_MULH,   32'h8000_0000, 32'h8000_0000, 1'b0);
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(f3, a, b, 1'b0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        last_exp  = '0;
        RESET     = 1'b0;
        OP_VALID  = 1'b0;
        FUNCT3    = '0;
        OPERAND1  = '0;
        OPERAND2  = '0;
        FLUSH     = 1'b0;

        test_reset();
        test_mul();
        test_div();
        test_special_div();
        test_reset_mid_div();
        test_flush();
        test_back_to_back();
        test_random();

        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size());
        else pass_cnt++;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage. It consumes the operands and decoded op held in the ID/EX pipeline register. It stalls the front of the pipeline while it computes, then presents a 32-bit result for the EX/MEM register. One operation is in flight at a time; radix-2 shift-add multiply and restoring divide, one bit per cycle.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
ITER, 32, iteration cycles per mul/div (must equal XLEN)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous reset, active-low
OP_VALID  input  1  EX holds an M-extension instruction
FUNCT3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
OPERAND1  input  32  rs1 value (post-forwarding)
OPERAND2  input  32  rs2 value (post-forwarding)
FLUSH  input  1  branch/jump squash of the EX instruction
STALL  output  1  hold PC, IF/ID and ID/EX this cycle
RESULT  output  32  operation result
RESULT_VALID  output  1  RESULT valid this cycle; EX/MEM captures it

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, counter=0, RESULT=0, RESULT_VALID=0, internal accumulators=0. STALL=0 while RESET=0. Reset mid-operation aborts the operation with no result.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - If OP_VALID=1 and FLUSH=0 at a rising edge, latch FUNCT3 and both operands, clear counter, and convert signed operands to magnitudes with recorded signs.
  - Operand signedness by op: MULH/DIV/REM treat both operands as signed. MULHSU treats OPERAND1 as signed and OPERAND2 as unsigned. MUL/MULHU/DIVU/REMU treat both as unsigned.
  - Next state: MUL for FUNCT3[2]=0, DIV for FUNCT3[2]=1.
  - Special divides go directly to DONE instead of DIV:
    - Divide by zero: DIV/DIVU quotient=32'hFFFFFFFF; REM/REMU=OPERAND1.
    - Signed overflow (DIV/REM only, 32'h80000000 / 32'hFFFFFFFF): DIV=32'h80000000, REM=0.
- MUL: one shift-add step per cycle on a 64-bit product. Leave after counter reaches ITER-1 (32 cycles in MUL), then go to DONE.
- DIV: one restoring step per cycle producing 32-bit quotient and remainder. Same 32-cycle count, then go to DONE.
- DONE:
  - Apply sign fixes:
    - Negate the 64-bit product when operand signs differ.
    - Negate the quotient when signs differ.
    - The remainder takes the sign of the dividend.
  - Register RESULT: MUL=product[31:0]; MULH/MULHSU/MULHU=product[63:32]; DIV/DIVU=quotient; REM/REMU=remainder.
  - RESULT_VALID=1 for exactly this one cycle. Next state is unconditionally IDLE.
  - RESULT holds its value after DONE until the next DONE or reset.
- STALL (combinational) = OP_VALID & ~FLUSH & (state != DONE). It is asserted in the cycle the op first appears.
- Latency, measured from the cycle OP_VALID first rises (cycle 0):
  - Normal ops: cycles 1–32 compute, DONE in cycle 33. STALL is high for cycles 0–32 (33 cycles) and low in cycle 33, so ID/EX advances at the end of cycle 33.
  - Special divides: DONE in cycle 1, STALL high only in cycle 0.
- Operand/FUNCT3 changes after acceptance are ignored; the latched copies are used.
- FLUSH=1 in any state other than DONE: at the next edge go to IDLE, no RESULT_VALID, STALL forced 0 immediately. FLUSH in DONE does not change RESULT_VALID; the squash of that result is the downstream register's responsibility.
- Back-to-back M ops: the second op sees IDLE in the cycle after DONE and is accepted with no bubble beyond its own latency.
- OP_VALID=0 in IDLE: remain IDLE, STALL=0, RESULT_VALID=0.

Test Plan:
- Reset: hold RESET=0 with OP_VALID=1 -> STALL=0, RESULT=0, RESULT_VALID=0. Assert RESET=0 mid-DIV at cycle 10 -> IDLE immediately, no RESULT_VALID.
- MUL 7 x -3 (32'hFFFFFFFD) -> STALL high cycles 0–32; cycle 33 RESULT_VALID=1, RESULT=32'hFFFFFFEB. MULH of the same operands -> 32'hFFFFFFFF. MULHU -> 32'h00000006.
- DIV -20 / 6 -> quotient 32'hFFFFFFFD. REM -20 / 6 -> 32'hFFFFFFFE. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2. All at cycle 33.
- Divide by zero: DIV 5 / 0 -> RESULT=32'hFFFFFFFF at cycle 1; REM 5 / 0 -> 5; STALL high only in cycle 0. DIV 32'h80000000 / -1 -> 32'h80000000; REM of the same -> 0; both at cycle 1.
- FLUSH in cycle 15 of a MUL -> STALL=0 that cycle, IDLE next edge, no RESULT_VALID. A new MUL 3 x 4 at cycle 17 -> RESULT=12 with RESULT_VALID at cycle 17+33.
- Back-to-back MULHSU(-1, 2) then DIVU(9, 3) -> first: RESULT=32'hFFFFFFFF, RESULT_VALID at cycle 33. Second: RESULT=3, RESULT_VALID at cycle 67. RESULT_VALID stays low between the two.
